shift_pipe: RTL

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage logarithmic shifter/rotator with valid/ready flow.
// Stage 1 applies the low shift bits, stage 2 the rest plus the flags.

module shift_s1_stage #(
  parameter int WIDTH = 32,
  parameter int AW = $clog2(WIDTH) + 1,
  parameter int S1B = AW / 2
) (
  input  logic [1:0]       mode,
  input  logic [S1B-1:0]   k,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH:0]   data
);

  logic is_shl;
  logic is_shr;
  logic is_sar;

  assign is_shl = (mode == 2'b00);
  assign is_shr = (mode == 2'b01);
  assign is_sar = (mode == 2'b10);

  // Extra bit holds the last bit shifted out: top for SHL, bottom for SHR/SAR.
  always_comb begin
    data = '0;
    unique case (1'b1)
      is_shl: data = {1'b0, din} << k;
      is_shr: data = {din, 1'b0} >> k;
      is_sar: data = $unsigned($signed({din, 1'b0}) >>> k);
      default: data = {1'b0, WIDTH'({din, din} >> k)};
    endcase
  end

endmodule

module shift_s2_stage #(
  parameter int WIDTH = 32,
  parameter int AW = $clog2(WIDTH) + 1,
  parameter int S1B = AW / 2
) (
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    n,
  input  logic [WIDTH:0]   data,
  output logic [WIDTH-1:0] res,
  output logic             cy
);

  logic is_shl;
  logic is_shr;
  logic is_sar;
  logic [AW-1:0] amt;
  logic [AW-2:0] ramt;
  logic rot_nz;
  logic [WIDTH:0] ext;
  logic [WIDTH-1:0] rot;

  assign is_shl = (mode == 2'b00);
  assign is_shr = (mode == 2'b01);
  assign is_sar = (mode == 2'b10);

  // Shifts keep the out-of-range bit; rotation drops it (mod WIDTH).
  assign amt = {n[AW-1:S1B], {S1B{1'b0}}};
  assign ramt = {n[AW-2:S1B], {S1B{1'b0}}};
  assign rot_nz = |n[AW-2:0];

  // Finish the shift; oversize amounts flush to zero or sign naturally.
  always_comb begin
    ext = '0;
    rot = '0;
    res = '0;
    cy = 1'b0;
    unique case (1'b1)
      is_shl: begin
        ext = data << amt;
        res = ext[WIDTH-1:0];
        cy = ext[WIDTH];
      end
      is_shr: begin
        ext = data >> amt;
        res = ext[WIDTH:1];
        cy = ext[0];
      end
      is_sar: begin
        ext = $unsigned($signed(data) >>> amt);
        res = ext[WIDTH:1];
        cy = ext[0];
      end
      default: begin
        rot = WIDTH'({data[WIDTH-1:0], data[WIDTH-1:0]} >> ramt);
        res = rot;
        cy = rot_nz & rot[WIDTH-1];
      end
    endcase
  end

endmodule

module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int AW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    n,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             zero
);

  localparam int S1B = AW / 2;

  logic             s1_valid;
  logic [1:0]       s1_mode;
  logic [AW-1:0]    s1_n;
  logic [WIDTH:0]   s1_data;
  logic             s2_adv;
  logic             accept;
  logic [WIDTH:0]   pre;
  logic [WIDTH-1:0] res;
  logic             cy;

  assign s2_adv = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign accept = in_valid && in_ready;

  shift_s1_stage #(
    .WIDTH(WIDTH),
    .AW(AW),
    .S1B(S1B)
  ) u_s1 (
    .mode(mode),
    .k(n[S1B-1:0]),
    .din(din),
    .data(pre)
  );

  shift_s2_stage #(
    .WIDTH(WIDTH),
    .AW(AW),
    .S1B(S1B)
  ) u_s2 (
    .mode(s1_mode),
    .n(s1_n),
    .data(s1_data),
    .res(res),
    .cy(cy)
  );

  // Stage 1: capture partially shifted operand; drain when it moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode <= '0;
      s1_n <= '0;
      s1_data <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_mode <= mode;
      s1_n <= n;
      s1_data <= pre;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout <= '0;
      carry <= 1'b0;
      zero <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      dout <= res;
      carry <= cy;
      zero <= (res == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
